dmem_arbiter: RTL and testbench

//  Two-port arbiter/sequencer in front of the byte-wide data memory (64 x 32-bit words, lb/sb only).

---
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the byte-wide data memory.
// Each access takes two cycles: ISSUE (gnt + memory strobe), then RESP (rvalid + data).
module dmem_arbiter #(
    parameter int unsigned DEPTH_BYTES = 256,
    parameter bit          FIXED_PRIO  = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic [2:0]  a_funct3,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    input  logic [2:0]  b_funct3,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    output logic        a_err,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,
    output logic        b_err,
    output logic        busy,
    output logic [31:0] MemSum,
    output logic [31:0] WriteData,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [2:0]  Funct3,
    input  logic [31:0] ReadData
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e      state_q;
    logic        we_q, owner_q, err_q, last_q;  // owner/last: 0 = A, 1 = B
    logic        load_ok_q;
    logic        a_gnt_q, b_gnt_q, a_rvalid_q, b_rvalid_q, a_err_q, b_err_q;
    logic        mem_read_q, mem_write_q;
    logic [31:0] mem_sum_q, write_data_q;
    logic [2:0]  funct3_q;

    logic        pick_b, sel_we, sel_err;
    logic [31:0] sel_addr, sel_wdata;
    logic [2:0]  sel_f3;

    always_comb begin
        if (a_req && b_req) begin
            pick_b = FIXED_PRIO ? 1'b0 : !last_q;
        end else begin
            pick_b = b_req;
        end
        sel_we    = pick_b ? b_we     : a_we;
        sel_addr  = pick_b ? b_addr   : a_addr;
        sel_wdata = pick_b ? b_wdata  : a_wdata;
        sel_f3    = pick_b ? b_funct3 : a_funct3;
        sel_err   = (sel_f3 != 3'b000) || (sel_addr >= 32'(DEPTH_BYTES));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_q       <= 1'b1;
            we_q         <= 1'b0;
            owner_q      <= 1'b0;
            err_q        <= 1'b0;
            load_ok_q    <= 1'b0;
            a_gnt_q      <= 1'b0;
            b_gnt_q      <= 1'b0;
            a_rvalid_q   <= 1'b0;
            b_rvalid_q   <= 1'b0;
            a_err_q      <= 1'b0;
            b_err_q      <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_sum_q    <= '0;
            write_data_q <= '0;
            funct3_q     <= '0;
        end else begin
            // Every output is a single-cycle pulse unless re-armed below.
            a_gnt_q      <= 1'b0;
            b_gnt_q      <= 1'b0;
            a_rvalid_q   <= 1'b0;
            b_rvalid_q   <= 1'b0;
            a_err_q      <= 1'b0;
            b_err_q      <= 1'b0;
            load_ok_q    <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_sum_q    <= '0;
            write_data_q <= '0;
            funct3_q     <= '0;
            unique case (state_q)
                StIdle, StResp: begin
                    if (a_req || b_req) begin
                        state_q      <= StIssue;
                        we_q         <= sel_we;
                        owner_q      <= pick_b;
                        err_q        <= sel_err;
                        last_q       <= pick_b;
                        a_gnt_q      <= !pick_b;
                        b_gnt_q      <= pick_b;
                        mem_sum_q    <= sel_addr;
                        write_data_q <= sel_wdata;
                        funct3_q     <= sel_f3;
                        mem_read_q   <= !sel_we && !sel_err;
                        mem_write_q  <= sel_we && !sel_err;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StIssue: begin
                    state_q    <= StResp;
                    a_rvalid_q <= !owner_q;
                    b_rvalid_q <= owner_q;
                    a_err_q    <= !owner_q && err_q;
                    b_err_q    <= owner_q && err_q;
                    load_ok_q  <= !we_q && !err_q;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // ReadData is registered inside the memory, so it is only valid during RESP.
    assign a_rdata   = (a_rvalid_q && load_ok_q) ? ReadData : '0;
    assign b_rdata   = (b_rvalid_q && load_ok_q) ? ReadData : '0;
    assign a_gnt     = a_gnt_q;
    assign b_gnt     = b_gnt_q;
    assign a_rvalid  = a_rvalid_q;
    assign b_rvalid  = b_rvalid_q;
    assign a_err     = a_err_q;
    assign b_err     = b_err_q;
    assign busy      = (state_q != StIdle);
    assign MemSum    = mem_sum_q;
    assign WriteData = write_data_q;
    assign MemRead   = mem_read_q;
    assign MemWrite  = mem_write_q;
    assign Funct3    = funct3_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural byte memory, per-port response scoreboard,
// round-robin and fixed-priority instances.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [2:0]  a_funct3, b_funct3;
    logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err, busy;
    logic [31:0] a_rdata, b_rdata, MemSum, WriteData, ReadData;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;

    // Fixed-priority instance: only its grants are observed.
    logic        p_a_req, p_b_req;
    logic        p_a_gnt, p_a_rvalid, p_a_err, p_b_gnt, p_b_rvalid, p_b_err, p_busy;
    logic [31:0] p_a_rdata, p_b_rdata, p_mem_sum, p_write_data;
    logic        p_mem_read, p_mem_write;
    logic [2:0]  p_funct3;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    resp_t       exp_a[$];
    resp_t       exp_b[$];
    logic [7:0]  shadow [256];
    logic [7:0]  mem [256];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH_BYTES(256), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_funct3(a_funct3),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_funct3(b_funct3),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
        .busy(busy), .MemSum(MemSum), .WriteData(WriteData), .MemRead(MemRead),
        .MemWrite(MemWrite), .Funct3(Funct3), .ReadData(ReadData)
    );

    dmem_arbiter #(.DEPTH_BYTES(256), .FIXED_PRIO(1'b1)) dut_fixed (
        .clk(clk), .reset(reset),
        .a_req(p_a_req), .a_we(1'b1), .a_addr(32'h1), .a_wdata(32'h3C), .a_funct3(3'b000),
        .b_req(p_b_req), .b_we(1'b1), .b_addr(32'h2), .b_wdata(32'h4D), .b_funct3(3'b000),
        .a_gnt(p_a_gnt), .a_rvalid(p_a_rvalid), .a_rdata(p_a_rdata), .a_err(p_a_err),
        .b_gnt(p_b_gnt), .b_rvalid(p_b_rvalid), .b_rdata(p_b_rdata), .b_err(p_b_err),
        .busy(p_busy), .MemSum(p_mem_sum), .WriteData(p_write_data), .MemRead(p_mem_read),
        .MemWrite(p_mem_write), .Funct3(p_funct3), .ReadData(32'h0)
    );

    // Byte memory with registered, sign-extended lb data; X when not read.
    always @(posedge clk) begin
        if (MemWrite) mem[MemSum[7:0]] <= WriteData[7:0];
        if (MemRead) ReadData <= {{24{mem[MemSum[7:0]][7]}}, mem[MemSum[7:0]]};
        else ReadData <= 'x;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_str(input string tag, input string obs, input string exp);
        n_cmp++;
        assert (obs == exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed '%s' expected '%s'", tag, obs, exp);
        end
    endtask

    // One clock; at the falling edge model grants, check the bus and score responses.
    task automatic cyc();
        logic        we, err, e_rd, e_wr;
        logic [31:0] addr, wd, e_sum, e_wd;
        logic [2:0]  f3, e_f3;
        logic [7:0]  byte_v;
        resp_t       r;
        @(negedge clk);
        e_sum = '0; e_wd = '0; e_f3 = '0; e_rd = 1'b0; e_wr = 1'b0;
        chk("one_gnt", {31'b0, a_gnt & b_gnt}, 32'd0);
        if (a_gnt || b_gnt) begin
            we   = a_gnt ? a_we : b_we;
            addr = a_gnt ? a_addr : b_addr;
            wd   = a_gnt ? a_wdata : b_wdata;
            f3   = a_gnt ? a_funct3 : b_funct3;
            err  = (f3 != 3'b000) || (addr >= 32'd256);
            e_sum = addr; e_wd = wd; e_f3 = f3;
            e_rd = !we && !err;
            e_wr = we && !err;
            byte_v = shadow[addr[7:0]];
            r.err   = err;
            r.rdata = e_rd ? {{24{byte_v[7]}}, byte_v} : 32'd0;
            if (e_wr) shadow[addr[7:0]] = wd[7:0];
            if (a_gnt) exp_a.push_back(r);
            else exp_b.push_back(r);
        end
        chk("MemRead", {31'b0, MemRead}, {31'b0, e_rd});
        chk("MemWrite", {31'b0, MemWrite}, {31'b0, e_wr});
        chk("MemSum", MemSum, e_sum);
        chk("WriteData", WriteData, e_wd);
        chk("Funct3", {29'b0, Funct3}, {29'b0, e_f3});
        chk("rvalid_excl", {31'b0, a_rvalid & b_rvalid}, 32'd0);
        if (a_rvalid) begin
            if (exp_a.size() == 0) chk("a_spurious_rvalid", {31'b0, a_rvalid}, 32'd0);
            else begin
                r = exp_a.pop_front();
                chk("a_err", {31'b0, a_err}, {31'b0, r.err});
                chk("a_rdata", a_rdata, r.rdata);
            end
        end else begin
            chk("a_err_idle", {31'b0, a_err}, 32'd0);
            chk("a_rdata_idle", a_rdata, 32'd0);
        end
        if (b_rvalid) begin
            if (exp_b.size() == 0) chk("b_spurious_rvalid", {31'b0, b_rvalid}, 32'd0);
            else begin
                r = exp_b.pop_front();
                chk("b_err", {31'b0, b_err}, {31'b0, r.err});
                chk("b_rdata", b_rdata, r.rdata);
            end
        end else begin
            chk("b_err_idle", {31'b0, b_err}, 32'd0);
            chk("b_rdata_idle", b_rdata, 32'd0);
        end
    endtask

    task automatic set_a(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] f3);
        a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; a_funct3 = f3;
    endtask

    task automatic set_b(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] f3);
        b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; b_funct3 = f3;
    endtask

    // Single access from IDLE; returns what the owner saw in RESP.
    task automatic single(input bit on_b, output logic [31:0] rd, output logic er);
        cyc();
        chk("gnt_latency", {31'b0, on_b ? b_gnt : a_gnt}, 32'd1);
        chk("busy_issue", {31'b0, busy}, 32'd1);
        a_req = 1'b0; b_req = 1'b0;
        cyc();
        chk("rvalid_latency", {31'b0, on_b ? b_rvalid : a_rvalid}, 32'd1);
        rd = on_b ? b_rdata : a_rdata;
        er = on_b ? b_err : a_err;
        chk("busy_resp", {31'b0, busy}, 32'd1);
        cyc();
        chk("busy_idle", {31'b0, busy}, 32'd0);
    endtask

    // Both ports already requesting: collect n grants, check order, spacing and busy.
    task automatic run_tie(input int n, input string exp_order);
        string order = "";
        int    last = 0;
        int    ng = 0;
        for (int c = 0; c < 40 && ng < n; c++) begin
            cyc();
            if (ng > 0) chk("busy_tie", {31'b0, busy}, 32'd1);
            if (a_gnt || b_gnt) begin
                order = {order, a_gnt ? "A" : "B"};
                if (ng > 0) chk("gnt_gap", c - last, 32'd2);
                last = c;
                ng++;
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        cyc();
        chk_str("gnt_order", order, exp_order);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        string       order2;
        reset = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_funct3 = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_funct3 = '0;
        p_a_req = 1'b0; p_b_req = 1'b0;
        cyc();
        cyc();
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_gnt", {30'b0, a_gnt, b_gnt}, 32'd0);
        reset = 1'b0;
        cyc();

        // Store then sign-extended load on A.
        set_a(1'b1, 32'h05, 32'hAB, 3'b000);
        single(1'b0, rd, er);
        chk("t1_err", {31'b0, er}, 32'd0);
        set_a(1'b0, 32'h05, 32'h0, 3'b000);
        single(1'b0, rd, er);
        chk("t2_rdata", rd, 32'hFFFF_FFAB);

        // Rejected accesses on B: bad width, then out-of-range address.
        set_b(1'b0, 32'h08, 32'h0, 3'b010);
        single(1'b1, rd, er);
        chk("t4_f3_err", {31'b0, er}, 32'd1);
        chk("t4_f3_rdata", rd, 32'd0);
        set_b(1'b1, 32'h100, 32'h55, 3'b000);
        single(1'b1, rd, er);
        chk("t4_addr_err", {31'b0, er}, 32'd1);
        chk("t4_addr_rdata", rd, 32'd0);

        // Tied stores, then tied back-to-back loads.
        set_a(1'b1, 32'h20, 32'h11, 3'b000);
        set_b(1'b1, 32'h21, 32'h7F, 3'b000);
        run_tie(4, "ABAB");
        set_a(1'b0, 32'h20, 32'h0, 3'b000);
        set_b(1'b0, 32'h05, 32'h0, 3'b000);
        run_tie(6, "ABABAB");
        cyc();

        // Make A the last owner, then reset during the ISSUE of another A load.
        set_a(1'b0, 32'h21, 32'h0, 3'b000);
        single(1'b0, rd, er);
        chk("t6_rdata", rd, 32'h0000_007F);
        set_a(1'b0, 32'h05, 32'h0, 3'b000);
        cyc();
        chk("t6_gnt", {31'b0, a_gnt}, 32'd1);
        reset = 1'b1;
        a_req = 1'b0;
        exp_a.delete();
        cyc();
        chk("t6_rst_busy", {31'b0, busy}, 32'd0);
        chk("t6_rst_gnt", {30'b0, a_gnt, b_gnt}, 32'd0);
        reset = 1'b0;
        cyc();
        chk("t6_no_rvalid", {30'b0, a_rvalid, b_rvalid}, 32'd0);
        set_a(1'b1, 32'h30, 32'h01, 3'b000);
        set_b(1'b1, 32'h31, 32'h02, 3'b000);
        run_tie(2, "AB");
        cyc();
        chk("a_queue_drained", exp_a.size(), 32'd0);
        chk("b_queue_drained", exp_b.size(), 32'd0);

        // Fixed priority: B starves while A keeps requesting.
        order2 = "";
        p_a_req = 1'b1; p_b_req = 1'b1;
        for (int c = 0; c < 20 && order2.len() < 4; c++) begin
            @(negedge clk);
            if (p_a_gnt) order2 = {order2, "A"};
            if (p_b_gnt) order2 = {order2, "B"};
        end
        p_a_req = 1'b0; p_b_req = 1'b0;
        chk_str("fixed_order", order2, "AAAA");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
